// File: rtl/alu_flags_ir.sv
// Datapath core: 32-bit combinational ALU with N/Z/C/V flags, plus the
// registered condition-flag register and instruction register.
module alu_flags_ir (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  OP,
  input  logic        CIN,
  input  logic        FRLd,
  input  logic        IRLd,
  input  logic [31:0] IR_IN,
  output logic [31:0] RESULT,
  output logic        FLAG_N,
  output logic        FLAG_Z,
  output logic        FLAG_C,
  output logic        FLAG_V,
  output logic [3:0]  FDR_OUT,
  output logic [31:0] IR_OUT
);

  logic [31:0] add_p;
  logic [31:0] add_q;
  logic        add_c;
  logic        is_arith;
  logic        plus_four;
  logic [31:0] logic_res;
  logic [32:0] sum;
  logic [3:0]  fdr_reg;
  logic [31:0] ir_reg;

  always_comb begin
    add_p     = '0;
    add_q     = '0;
    add_c     = 1'b0;
    is_arith  = 1'b0;
    plus_four = 1'b0;
    logic_res = '0;
    case (OP)
      5'b00000: logic_res = A & B;
      5'b00001: logic_res = A ^ B;
      5'b00010: begin add_p = A; add_q = ~B; add_c = 1'b1; is_arith = 1'b1; end
      5'b00011: begin add_p = B; add_q = ~A; add_c = 1'b1; is_arith = 1'b1; end
      5'b00100: begin add_p = A; add_q = B;  add_c = 1'b0; is_arith = 1'b1; end
      5'b00101: begin add_p = A; add_q = B;  add_c = CIN;  is_arith = 1'b1; end
      5'b00110: begin add_p = A; add_q = ~B; add_c = CIN;  is_arith = 1'b1; end
      5'b00111: begin add_p = B; add_q = ~A; add_c = CIN;  is_arith = 1'b1; end
      5'b01000: logic_res = A & B;
      5'b01001: logic_res = A ^ B;
      5'b01010: begin add_p = A; add_q = ~B; add_c = 1'b1; is_arith = 1'b1; end
      5'b01011: begin add_p = A; add_q = B;  add_c = 1'b0; is_arith = 1'b1; end
      5'b01100: logic_res = A | B;
      5'b01101: logic_res = B;
      5'b01110: logic_res = A & ~B;
      5'b01111: logic_res = ~B;
      5'b10000: logic_res = A;
      5'b10001: begin add_p = A; add_q = 32'd4;  add_c = 1'b0; is_arith = 1'b1; end
      5'b10010: begin add_p = A; add_q = B;      add_c = 1'b0; is_arith = 1'b1; plus_four = 1'b1; end
      5'b10011: begin add_p = A; add_q = ~32'd4; add_c = 1'b1; is_arith = 1'b1; end
      default:  logic_res = '0;
    endcase

    sum = {1'b0, add_p} + {1'b0, add_q} + {32'd0, add_c};

    // A+B+4: C/V come from the A+B step; the extra 4 only affects RESULT.
    if (is_arith) begin
      RESULT = plus_four ? (sum[31:0] + 32'd4) : sum[31:0];
      FLAG_C = sum[32];
      FLAG_V = (add_p[31] == add_q[31]) && (sum[31] != add_p[31]);
    end else begin
      RESULT = logic_res;
      FLAG_C = CIN;
      FLAG_V = 1'b0;
    end
    FLAG_N = RESULT[31];
    FLAG_Z = (RESULT == 32'd0);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      fdr_reg <= 4'b0000;
      ir_reg  <= 32'd0;
    end else begin
      if (FRLd) fdr_reg <= {FLAG_N, FLAG_Z, FLAG_C, FLAG_V};
      if (IRLd) ir_reg  <= IR_IN;
    end
  end

  assign FDR_OUT = fdr_reg;
  assign IR_OUT  = ir_reg;

endmodule

// File: tb/tb_alu_flags_ir.sv
// Directed bench for alu_flags_ir: hand-computed ALU vectors and
// flag/instruction register load, hold and clear sequences.
module tb_alu_flags_ir;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [4:0]  OP = '0;
  logic        CIN = 1'b0;
  logic        FRLd = 1'b0;
  logic        IRLd = 1'b0;
  logic [31:0] IR_IN = '0;
  logic [31:0] RESULT;
  logic        FLAG_N, FLAG_Z, FLAG_C, FLAG_V;
  logic [3:0]  FDR_OUT;
  logic [31:0] IR_OUT;

  int n_checks = 0;
  int n_fail   = 0;

  alu_flags_ir dut (
    .CLK(CLK), .CLR(CLR), .A(A), .B(B), .OP(OP), .CIN(CIN),
    .FRLd(FRLd), .IRLd(IRLd), .IR_IN(IR_IN),
    .RESULT(RESULT), .FLAG_N(FLAG_N), .FLAG_Z(FLAG_Z),
    .FLAG_C(FLAG_C), .FLAG_V(FLAG_V), .FDR_OUT(FDR_OUT), .IR_OUT(IR_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive ALU inputs in the low phase, then check combinational outputs.
  task automatic alu_step(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic cin,
                          input logic [31:0] exp_r, input logic [3:0] exp_f);
    @(negedge CLK);
    OP = op; A = a; B = b; CIN = cin;
    #1;
    $display("step %s op=%b a=%h b=%h cin=%b -> result=%h nzcv=%b%b%b%b",
             tag, op, a, b, cin, RESULT, FLAG_N, FLAG_Z, FLAG_C, FLAG_V);
    check({tag, "_result"}, RESULT, exp_r);
    check({tag, "_flags"}, {28'd0, FLAG_N, FLAG_Z, FLAG_C, FLAG_V}, {28'd0, exp_f});
  endtask

  task automatic clock_regs(input string tag, input logic [3:0] exp_fdr, input logic [31:0] exp_ir);
    @(posedge CLK);
    #1;
    $display("clock %s clr=%b frld=%b irld=%b -> fdr=%b ir=%h",
             tag, CLR, FRLd, IRLd, FDR_OUT, IR_OUT);
    check({tag, "_fdr"}, {28'd0, FDR_OUT}, {28'd0, exp_fdr});
    check({tag, "_ir"}, IR_OUT, exp_ir);
  endtask

  initial begin
    // Reset
    @(negedge CLK); CLR = 1'b1;
    clock_regs("reset", 4'b0000, 32'h0);
    @(negedge CLK); CLR = 1'b0;

    // ADD overflow-to-zero, captured in flag register
    alu_step("add_wrap", 5'b00100, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 4'b0110);
    FRLd = 1'b1;
    clock_regs("fr_load_add", 4'b0110, 32'h0);

    // Hold with FRLd=0 while ALU flags change
    alu_step("sub_neg", 5'b00010, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 4'b1000);
    FRLd = 1'b0;
    clock_regs("fr_hold", 4'b0110, 32'h0);

    alu_step("cmp_neg", 5'b01010, 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 4'b1000);
    alu_step("add_ovf", 5'b00100, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 4'b1001);
    alu_step("sub_ovf", 5'b00010, 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 4'b0011);
    alu_step("adc", 5'b00101, 32'd1, 32'd1, 1'b1, 32'd3, 4'b0000);
    alu_step("sbc", 5'b00110, 32'd5, 32'd2, 1'b0, 32'd2, 4'b0010);
    alu_step("rsb", 5'b00011, 32'd2, 32'd5, 1'b0, 32'd3, 4'b0010);
    alu_step("rsc", 5'b00111, 32'd1, 32'd3, 1'b0, 32'd1, 4'b0010);
    alu_step("a_plus4", 5'b10001, 32'h20, 32'h0, 1'b0, 32'h24, 4'b0000);
    alu_step("ab_plus4", 5'b10010, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h4, 4'b0010);
    alu_step("a_minus4", 5'b10011, 32'd2, 32'h0, 1'b0, 32'hFFFF_FFFE, 4'b1000);
    alu_step("mvn", 5'b01111, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFF, 4'b1000);
    alu_step("and_cin", 5'b00000, 32'hF0, 32'h0F, 1'b1, 32'h0, 4'b0110);
    alu_step("bic", 5'b01110, 32'hFF, 32'h0F, 1'b0, 32'hF0, 4'b0000);
    alu_step("teq", 5'b01001, 32'hA5A5_A5A5, 32'h0000_FFFF, 1'b0, 32'hA5A5_5A5A, 4'b1000);
    alu_step("pass_a", 5'b10000, 32'h1234_5678, 32'h0, 1'b1, 32'h1234_5678, 4'b0010);
    alu_step("undef", 5'b10100, 32'd5, 32'd5, 1'b1, 32'h0, 4'b0110);

    // Instruction register load, hold, clear-with-load
    @(negedge CLK); IRLd = 1'b1; IR_IN = 32'hE3A0_1005;
    clock_regs("ir_load", 4'b0110, 32'hE3A0_1005);
    @(negedge CLK); IRLd = 1'b0; IR_IN = 32'h1234_5678;
    clock_regs("ir_hold", 4'b0110, 32'hE3A0_1005);
    @(negedge CLK); CLR = 1'b1; IRLd = 1'b1; IR_IN = 32'hDEAD_BEEF;
    clock_regs("ir_clr", 4'b0000, 32'h0);
    @(negedge CLK); CLR = 1'b0; IRLd = 1'b0;

    // Both registers load together: SUB 5-7 gives 1000
    alu_step("sub_load", 5'b00010, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 4'b1000);
    FRLd = 1'b1; IRLd = 1'b1; IR_IN = 32'hE080_2003;
    clock_regs("both_load", 4'b1000, 32'hE080_2003);

    // Clear beats FRLd, then hold zero regardless of ALU flags
    @(negedge CLK); CLR = 1'b1; FRLd = 1'b1; IRLd = 1'b0;
    clock_regs("fr_clr", 4'b0000, 32'h0);
    alu_step("add_after_clr", 5'b00100, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 4'b0110);
    CLR = 1'b0; FRLd = 1'b0;
    clock_regs("fr_hold_zero", 4'b0000, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
